// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and helpers for the CPU divider
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    // Width of a counter that must hold the values 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cpu_divider_radix_if.sv
// rtl/cpu_divider_radix_if.sv - launch/result bundle between execute stage and divider
interface cpu_divider_radix_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             signed_div;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, data_a, data_b, signed_div,
        input  quotient, remainder, busy, done
    );

    modport slave (
        input  start, abort, data_a, data_b, signed_div,
        output quotient, remainder, busy, done
    );
endinterface

// File: rtl/cpu_divider_step.sv
// rtl/cpu_divider_step.sv - one combinational radix-2 restoring division step
module cpu_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH:0]   rem_out,
    output logic             quo_bit
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   trial;

    assign shifted = {rem_in, dividend_bit};
    // Only the low bits of the difference matter: it is kept only when no borrow occurs
    assign trial   = shifted[WIDTH:0] - {1'b0, divisor};
    assign quo_bit = (shifted >= {2'b00, divisor});
    assign rem_out = quo_bit ? trial : shifted[WIDTH:0];
endmodule

// File: rtl/cpu_divider_radix.sv
// rtl/cpu_divider_radix.sv - iterative restoring divider retiring BITS_PER_CYCLE quotient bits per cycle
module cpu_divider_radix
    import cpu_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int EARLY_OUT      = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    cpu_divider_radix_if.slave   bus
);
    localparam int K  = BITS_PER_CYCLE;
    localparam int N  = WIDTH / K;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0]    LAST    = CW'(N - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    if ((K != 1 && K != 2 && K != 4) || (WIDTH % K) != 0 || WIDTH < 8 || (WIDTH % 2) != 0) begin : g_param_check
        $error("cpu_divider_radix: illegal WIDTH/BITS_PER_CYCLE combination");
    end

    div_state_e       state, state_nxt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   prem_nxt;
    logic [K-1:0]     qbits;
    logic [CW-1:0]    cnt;
    logic             sign_q, sign_r;
    logic [WIDTH-1:0] q_out, r_out;

    logic             launch, neg_a, neg_b, div_zero, ovf, early, fast;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign launch   = bus.start & ~bus.abort;
    assign neg_a    = bus.signed_div & bus.data_a[WIDTH-1];
    assign neg_b    = bus.signed_div & bus.data_b[WIDTH-1];
    assign abs_a    = neg_a ? -bus.data_a : bus.data_a;
    assign abs_b    = neg_b ? -bus.data_b : bus.data_b;
    assign div_zero = (bus.data_b == '0);
    assign ovf      = bus.signed_div && (bus.data_a == MIN_VAL) && (bus.data_b == '1);
    assign early    = (EARLY_OUT != 0) && (abs_a < abs_b);
    assign fast     = div_zero | ovf | early;

    // Chain of restoring steps; dividend bits are consumed MSB first
    for (genvar i = 0; i < K; i++) begin : g_step
        logic [WIDTH:0] rem_in;
        logic [WIDTH:0] rem_o;
        logic           q;
        if (i == 0) begin : g_first
            assign rem_in = prem;
        end else begin : g_next
            assign rem_in = g_step[i-1].rem_o;
        end
        cpu_divider_step #(.WIDTH(WIDTH)) u_step (
            .rem_in       (rem_in),
            .divisor      (dsr),
            .dividend_bit (dvd[WIDTH-1-i]),
            .rem_out      (rem_o),
            .quo_bit      (q)
        );
        assign qbits[K-1-i] = q;
    end
    assign prem_nxt = g_step[K-1].rem_o;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else if (launch) begin
            state_nxt = fast ? DONE : RUN;
        end else begin
            case (state)
                RUN:     if (cnt == LAST) state_nxt = FIXUP;
                FIXUP:   state_nxt = DONE;
                default: state_nxt = state;
            endcase
        end
    end

    // The dividend register doubles as the quotient register as bits shift through
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dvd    <= '0;
            dsr    <= '0;
            prem   <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            q_out  <= '0;
            r_out  <= '0;
        end else if (launch) begin
            sign_q <= bus.signed_div & (bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1]);
            sign_r <= neg_a;
            dvd    <= abs_a;
            dsr    <= abs_b;
            prem   <= '0;
            cnt    <= '0;
            if (div_zero) begin
                q_out <= '1;
                r_out <= bus.data_a;
            end else if (ovf) begin
                q_out <= MIN_VAL;
                r_out <= '0;
            end else if (early) begin
                q_out <= '0;
                r_out <= bus.data_a;
            end
        end else if (!bus.abort) begin
            case (state)
                RUN: begin
                    dvd  <= {dvd[WIDTH-K-1:0], qbits};
                    prem <= prem_nxt;
                    cnt  <= cnt + 1'b1;
                end
                FIXUP: begin
                    q_out <= sign_q ? -dvd : dvd;
                    r_out <= sign_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = q_out;
    assign bus.remainder = r_out;
    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_cpu_divider_radix.sv
// tb/tb_cpu_divider_radix.sv - scoreboard bench for cpu_divider_radix at 1, 2 and 4 bits per cycle
module tb_cpu_divider_radix;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        int          busy;
    } exp_t;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    cpu_divider_radix_if #(.WIDTH(32)) bus1 ();
    cpu_divider_radix_if #(.WIDTH(32)) bus2 ();
    cpu_divider_radix_if #(.WIDTH(32)) bus4 ();

    cpu_divider_radix #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1));
    cpu_divider_radix #(.WIDTH(32), .BITS_PER_CYCLE(2), .EARLY_OUT(1)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2));
    cpu_divider_radix #(.WIDTH(32), .BITS_PER_CYCLE(4), .EARLY_OUT(1)) dut4 (
        .clock(clock), .reset(reset), .bus(bus4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic s, input logic ab,
                         input logic [31:0] a, input logic [31:0] b, input logic sg);
        case (k)
            1: begin bus1.start = s; bus1.abort = ab; bus1.data_a = a; bus1.data_b = b; bus1.signed_div = sg; end
            2: begin bus2.start = s; bus2.abort = ab; bus2.data_a = a; bus2.data_b = b; bus2.signed_div = sg; end
            default: begin bus4.start = s; bus4.abort = ab; bus4.data_a = a; bus4.data_b = b; bus4.signed_div = sg; end
        endcase
    endtask

    function automatic logic get_done(input int k);
        return (k == 1) ? bus1.done : (k == 2) ? bus2.done : bus4.done;
    endfunction

    function automatic logic get_busy(input int k);
        return (k == 1) ? bus1.busy : (k == 2) ? bus2.busy : bus4.busy;
    endfunction

    function automatic logic [31:0] get_q(input int k);
        return (k == 1) ? bus1.quotient : (k == 2) ? bus2.quotient : bus4.quotient;
    endfunction

    function automatic logic [31:0] get_r(input int k);
        return (k == 1) ? bus1.remainder : (k == 2) ? bus2.remainder : bus4.remainder;
    endfunction

    function automatic logic [31:0] mag(input logic [31:0] v, input logic sg);
        return (sg && v[31]) ? -v : v;
    endfunction

    // Reference division using native operators plus the RISC-V special cases
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else if (sg) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // Latency is the index of the first edge after the launch edge (index 0) that shows done
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input logic [31:0] eq, input logic [31:0] er);
        exp_t e;
        int   lat;
        int   bcnt;
        logic fast;
        fast = (b == 32'd0) || (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ||
               (mag(a, sg) < mag(b, sg));
        e.q    = eq;
        e.r    = er;
        e.lat  = fast ? 0 : (32 / k) + 1;
        e.busy = fast ? 0 : (32 / k);
        sb.push_back(e);
        @(negedge clock);
        drive(k, 1'b1, 1'b0, a, b, sg);
        @(posedge clock);
        #1;
        drive(k, 1'b0, 1'b0, $urandom, $urandom, 1'($urandom));
        lat  = 0;
        bcnt = 0;
        while (!get_done(k) && lat < 100) begin
            if (get_busy(k)) bcnt++;
            @(posedge clock);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check_eq("done_seen", 64'(get_done(k)), 64'd1);
        check_eq("latency", 64'(lat), 64'(e.lat));
        check_eq("busy_cycles", 64'(bcnt), 64'(e.busy));
        check_eq("busy_at_done", 64'(get_busy(k)), 64'd0);
        check_eq("quotient", 64'(get_q(k)), 64'(e.q));
        check_eq("remainder", 64'(get_r(k)), 64'(e.r));
    endtask

    initial begin
        logic [31:0] a, b, mq, mr;
        logic        sg, seen;
        int          k;

        drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(4, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_eq("rst_quotient", 64'(bus1.quotient), 64'd0);
        check_eq("rst_remainder", 64'(bus1.remainder), 64'd0);
        check_eq("rst_busy", 64'(bus1.busy), 64'd0);
        check_eq("rst_done", 64'(bus4.done), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run_op(1, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        repeat (3) @(posedge clock);
        #1;
        check_eq("hold_done", 64'(bus1.done), 64'd1);
        check_eq("hold_quotient", 64'(bus1.quotient), 64'd14);
        check_eq("hold_remainder", 64'(bus1.remainder), 64'd2);

        run_op(1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op(1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
        run_op(1, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
        run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        run_op(1, 32'd3, 32'd10, 1'b0, 32'd0, 32'd3);
        run_op(4, 32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0);
        run_op(2, 32'h8000_0000, 32'd1, 1'b0, 32'h8000_0000, 32'd0);

        for (int i = 0; i < 9; i++) begin
            k  = (i % 3 == 0) ? 1 : (i % 3 == 1) ? 2 : 4;
            sg = 1'(i & 1);
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (sg && b[31] && i % 4 == 1) b = -b;
            model(a, b, sg, mq, mr);
            run_op(k, a, b, sg, mq, mr);
        end

        // Abort ten cycles into an operation
        @(negedge clock);
        drive(1, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
        @(posedge clock);
        #1 drive(1, 1'b0, 1'b0, 32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        drive(1, 1'b0, 1'b1, 32'd100, 32'd7, 1'b0);
        @(posedge clock);
        #1 drive(1, 1'b0, 1'b0, 32'd100, 32'd7, 1'b0);
        check_eq("abort_busy", 64'(bus1.busy), 64'd0);
        check_eq("abort_done", 64'(bus1.done), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clock);
            #1 seen = seen | bus1.done;
        end
        check_eq("abort_no_done", 64'(seen), 64'd0);
        run_op(1, 32'd50, 32'd6, 1'b0, 32'd8, 32'd2);

        // Asynchronous reset in the middle of an operation
        @(negedge clock);
        drive(1, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
        @(posedge clock);
        #1 drive(1, 1'b0, 1'b0, 32'd100, 32'd7, 1'b0);
        repeat (5) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check_eq("arst_quotient", 64'(bus1.quotient), 64'd0);
        check_eq("arst_remainder", 64'(bus1.remainder), 64'd0);
        check_eq("arst_busy", 64'(bus1.busy), 64'd0);
        check_eq("arst_done", 64'(bus1.done), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        run_op(1, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

        // start and abort together: abort wins
        @(negedge clock);
        drive(1, 1'b1, 1'b1, 32'd20, 32'd3, 1'b0);
        @(posedge clock);
        #1 drive(1, 1'b0, 1'b0, 32'd20, 32'd3, 1'b0);
        check_eq("startabort_done", 64'(bus1.done), 64'd0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clock);
            #1 seen = seen | bus1.busy | bus1.done;
        end
        check_eq("startabort_idle", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
